vga_pixel_probe: RTL and testbench

Inline read-back stage for the VGA pixel stream. It forwards the `vga_if` stream unchanged with one register stage and counts frames. On request it captures the RGB value of one screen coordinate from the next frame and returns it over a valid/ready handshake. It sits after the last drawing stage, before the VGA output, so a host can read back what the draw stages produced.

---
 rtl/vga_pixel_probe_if.sv | 13 +
 rtl/vga_pixel_probe.sv | 119 +++++++++++
 tb/tb_vga_pixel_probe.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_probe_if.sv
// VGA pixel stream bundle: raster counters, sync/blank flags and 12-bit RGB.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_pixel_probe.sv
// Inline VGA stream probe: forwards the stream through one register stage, counts
// frames and reads back the colour of one requested coordinate from the next frame.
module vga_pixel_probe #(
  parameter int X_W = 11,
  parameter int Y_W = 11
) (
  input  logic           clk,
  input  logic           rst,
  vga_if.in              in,
  vga_if.out             out,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [X_W-1:0] req_x,
  input  logic [Y_W-1:0] req_y,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [11:0]    rsp_rgb,
  output logic           rsp_err,
  output logic [15:0]    frame_cnt
);

  typedef enum logic [1:0] {IDLE, SYNC, SCAN, RESP} state_t;

  state_t         state, state_nxt;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic           fs;
  logic           hit;
  logic           cap_hit;
  logic           cap_miss;

  assign fs  = (in.hcount == '0) && (in.vcount == '0);
  assign hit = (in.hcount == x_q) && (in.vcount == y_q) && !in.hblnk && !in.vblnk;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // stage p0 -> p1: registered copy of the stream
  always_ff @(posedge clk) begin
    if (rst) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= in.hcount;
      out.vcount <= in.vcount;
      out.hsync  <= in.hsync;
      out.vsync  <= in.vsync;
      out.hblnk  <= in.hblnk;
      out.vblnk  <= in.vblnk;
      out.rgb    <= in.rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      frame_cnt <= '0;
      rsp_rgb   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fs)
        frame_cnt <= frame_cnt + 16'd1;
      if (cap_hit) begin
        rsp_rgb <= in.rgb;
        rsp_err <= 1'b0;
      end else if (cap_miss) begin
        rsp_rgb <= '0;
        rsp_err <= 1'b1;
      end
    end
  end

  // Coordinates are data: latched on acceptance, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      x_q <= req_x;
      y_q <= req_y;
    end
  end

  // A request never samples the frame in progress: SYNC waits for the next
  // frame start, then SCAN runs until a match or the following frame start.
  always_comb begin
    state_nxt = state;
    cap_hit   = 1'b0;
    cap_miss  = 1'b0;
    case (state)
      IDLE: if (req_valid) state_nxt = SYNC;
      SYNC: begin
        if (fs) begin
          if (hit) begin
            cap_hit   = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = SCAN;
          end
        end
      end
      SCAN: begin
        if (hit) begin
          cap_hit   = 1'b1;
          state_nxt = RESP;
        end else if (fs) begin
          cap_miss  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_pixel_probe.sv
// Scoreboard bench for vga_pixel_probe on a compressed raster whose horizontal
// blanking jumps to 896..903 so that (900,y) exists without a full-length line.
module tb_vga_pixel_probe;

  localparam int H_ACT = 128;
  localparam int LINE  = 144;
  localparam int V_ACT = 40;
  localparam int ROWS  = 42;
  localparam int FRAME = LINE * ROWS;

  typedef struct {
    logic [11:0] rgb;
    logic        err;
    int          when;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_x;
  logic [10:0] req_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [11:0] rsp_rgb;
  logic        rsp_err;
  logic [15:0] frame_cnt;

  vga_if vin ();
  vga_if vout ();

  vga_pixel_probe #(.X_W(11), .Y_W(11)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (vin),
    .out       (vout),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rgb   (rsp_rgb),
    .rsp_err   (rsp_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   pix     = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Raster generator: one pixel per clock, advanced just after each rising edge.
  task automatic drive_pixel(input int p);
    int pos, row, col;
    logic [10:0] h;
    logic [10:0] v;
    pos = p % FRAME;
    row = pos / LINE;
    col = pos % LINE;
    h = (col < 136) ? 11'(col) : 11'(896 + col - 136);
    v = 11'(row);
    vin.hcount = h;
    vin.vcount = v;
    vin.hblnk  = (col >= H_ACT);
    vin.vblnk  = (row >= V_ACT);
    vin.hsync  = (h >= 11'd896) && (h <= 11'd899);
    vin.vsync  = (row == ROWS - 1);
    vin.rgb    = {h[5:0], v[5:0]};
  endtask

  initial begin
    drive_pixel(0);
    forever begin
      @(posedge clk);
      #1;
      pix++;
      drive_pixel(pix);
    end
  end

  // Monitor: inputs and outputs are both settled on the falling edge.
  logic [37:0] prev_in    = '0;
  logic        prev_rst   = 1'b1;
  logic [15:0] exp_fc     = '0;
  logic        prev_valid = 1'b0;
  logic        released   = 1'b0;
  logic [11:0] held_rgb   = '0;
  logic        held_err   = 1'b0;

  always @(negedge clk) begin
    logic [37:0] cur_in;
    logic [37:0] exp_out;
    exp_t        e;
    int          f;
    cur_in  = {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, vin.rgb};
    exp_out = prev_rst ? '0 : prev_in;
    check("pass_through",
          {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb},
          exp_out);
    if (prev_rst)
      exp_fc = '0;
    else if (prev_in[37:16] == '0)
      exp_fc = exp_fc + 16'd1;
    check("frame_cnt", frame_cnt, exp_fc);

    if (released) begin
      check("req_ready_after_rsp", req_ready, 1);
      check("rsp_valid_after_rsp", rsp_valid, 0);
    end
    if (rsp_valid) begin
      check("req_ready_in_resp", req_ready, 0);
      if (!prev_valid) begin
        check("rsp_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rsp_rgb", rsp_rgb, e.rgb);
          check("rsp_err", rsp_err, e.err);
          check("rsp_time", pix, e.when);
        end
        held_rgb = rsp_rgb;
        held_err = rsp_err;
      end else begin
        check("rsp_rgb_hold", rsp_rgb, held_rgb);
        check("rsp_err_hold", rsp_err, held_err);
      end
    end

    // Expected response: pixel index of the capture in the next frame, plus one.
    if (req_valid && req_ready && !rst) begin
      f = ((pix + FRAME) / FRAME) * FRAME;
      if (req_x < H_ACT && req_y < V_ACT) begin
        e.rgb  = {req_x[5:0], req_y[5:0]};
        e.err  = 1'b0;
        e.when = f + int'(req_y) * LINE + int'(req_x) + 1;
      end else begin
        e.rgb  = '0;
        e.err  = 1'b1;
        e.when = f + FRAME + 1;
      end
      sb.push_back(e);
    end
    if (rst)
      sb.delete();

    released   = rsp_valid && rsp_ready && !rst;
    prev_valid = rsp_valid && !rsp_ready && !rst;
    prev_in    = cur_in;
    prev_rst   = rst;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (pix % FRAME == p) return;
      step(1);
    end
    check("wait_pos_timeout", pix % FRAME, p);
  endtask

  task automatic request(input int x, input int y);
    check("req_ready_idle", req_ready, 1);
    req_x     = 11'(x);
    req_y     = 11'(y);
    req_valid = 1'b1;
    step(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (rsp_valid) return;
      step(1);
    end
    check("rsp_timeout", rsp_valid, 1);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    req_x     = '0;
    req_y     = '0;
    step(5);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rgb", rsp_rgb, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;

    // Mid-frame request waits for the next frame.
    wait_pos(3000);
    request(100, 37);
    wait_rsp();
    check("cap_100_37_rgb", rsp_rgb, 12'h925);
    check("cap_100_37_err", rsp_err, 0);
    step(2);

    // Origin requested just before frame start.
    wait_pos(FRAME - 3);
    request(0, 0);
    wait_rsp();
    check("cap_origin_rgb", rsp_rgb, 12'h000);
    check("cap_origin_err", rsp_err, 0);
    step(2);

    // Coordinate inside horizontal blanking.
    wait_pos(500);
    request(900, 10);
    wait_rsp();
    check("oor_err", rsp_err, 1);
    check("oor_rgb", rsp_rgb, 12'h000);
    step(2);

    // Backpressure with an extra request while the response is held.
    rsp_ready = 1'b0;
    wait_pos(300);
    request(5, 3);
    wait_rsp();
    step(2);
    req_x     = 11'd7;
    req_y     = 11'd7;
    req_valid = 1'b1;
    step(1);
    req_valid = 1'b0;
    step(2);
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_rsp_rgb", rsp_rgb, {6'd5, 6'd3});
    rsp_ready = 1'b1;
    step(1);
    check("bp_req_ready", req_ready, 1);
    step(FRAME + 300);

    // Reset while scanning, then count three frame starts.
    wait_pos(200);
    request(900, 10);
    wait_pos(1000);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    for (int k = 0; k < 3; k++) begin
      step(1);
      wait_pos(1);
    end
    check("frame_cnt_3", frame_cnt, 3);
    step(2 * FRAME / 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
